// File: rtl/trng_byte_packer.sv
// Von Neumann debiaser, LSB-first byte packer and small byte FIFO for the trng raw bit stream.
// Optional repetition-count health test is built only when TRNG_HEALTH_EN is defined.
module trng_byte_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic                          i_bit,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic                          o_health_fail
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {WAIT_FIRST = 1'b0, WAIT_SECOND = 1'b1} phase_e;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_param
            $error("trng_byte_packer: FIFO_DEPTH must be a power of 2 >= 2 and REP_LIMIT in 2..255");
        end
    endgenerate

    phase_e          phase_q, phase_d;
    logic            first_q, first_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      sh_q, sh_d;
    logic [LW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            ovf_q, ovf_d;

    logic            accept_s, emit_v_s, emit_b_s, push_s, pop_s, wr_en_s;
    logic            full_s, empty_s, valid_s;
    logic            block_s, flush_s;
    logic [7:0]      byte_s;
    logic [LW-1:0]   level_s;

`ifdef TRNG_HEALTH_EN
    localparam logic [7:0] REP_LIM_C = 8'(REP_LIMIT);

    logic [7:0] rep_q, rep_d;
    logic       last_q, last_d;
    logic       hfail_q, hfail_d;
    logic       trip_s;

    // Run-length of identical raw bits; a run reaching REP_LIMIT latches the failure.
    always_comb begin
        rep_d   = rep_q;
        last_d  = last_q;
        trip_s  = 1'b0;
        if (i_valid && !hfail_q) begin
            if (rep_q != 8'd0 && i_bit == last_q) begin
                rep_d = (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;
            end else begin
                rep_d = 8'd1;
            end
            last_d = i_bit;
            trip_s = (rep_d == REP_LIM_C);
        end else begin
            trip_s = 1'b0;
        end
        hfail_d = hfail_q | trip_s;
    end

    // Health-test state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q   <= 8'd0;
            last_q  <= 1'b0;
            hfail_q <= 1'b0;
        end else begin
            rep_q   <= rep_d;
            last_q  <= last_d;
            hfail_q <= hfail_d;
        end
    end

    assign block_s       = hfail_q;
    assign flush_s       = hfail_q | trip_s;
    assign o_health_fail = hfail_q;
`else
    assign block_s       = 1'b0;
    assign flush_s       = 1'b0;
    assign o_health_fail = 1'b0;
`endif

    assign accept_s = i_valid & ~block_s;

    // Debiaser pair phase and packer next state.
    always_comb begin
        phase_d  = phase_q;
        first_d  = first_q;
        emit_v_s = 1'b0;
        emit_b_s = 1'b0;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        push_s   = 1'b0;
        byte_s   = sh_q;
        if (accept_s) begin
            case (phase_q)
                WAIT_FIRST: begin
                    first_d = i_bit;
                    phase_d = WAIT_SECOND;
                end
                WAIT_SECOND: begin
                    phase_d  = WAIT_FIRST;
                    emit_v_s = (first_q != i_bit);
                    emit_b_s = first_q;
                end
                default: phase_d = WAIT_FIRST;
            endcase
        end else begin
            phase_d = phase_q;
        end
        if (emit_v_s) begin
            byte_s[cnt_q] = emit_b_s;
            if (cnt_q == 3'd7) begin
                push_s = 1'b1;
                cnt_d  = 3'd0;
                sh_d   = 8'h00;
            end else begin
                cnt_d  = cnt_q + 3'd1;
                sh_d   = byte_s;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign level_s = wr_q - rd_q;
    assign full_s  = (level_s == LW'(FIFO_DEPTH));
    assign empty_s = (level_s == {LW{1'b0}});
    assign valid_s = ~empty_s & ~block_s;
    assign pop_s   = valid_s & i_ready;
    assign wr_en_s = push_s & (~full_s | pop_s) & ~flush_s;

    // FIFO pointers and sticky overflow; a pop frees the slot for a coincident push.
    always_comb begin
        ovf_d = ovf_q | (push_s & full_s & ~pop_s & ~flush_s);
        wr_d  = wr_q + LW'(wr_en_s);
        if (flush_s) begin
            rd_d = wr_q;
        end else begin
            rd_d = rd_q + LW'(pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= WAIT_FIRST;
            first_q <= 1'b0;
            cnt_q   <= 3'd0;
            sh_q    <= 8'h00;
            wr_q    <= {LW{1'b0}};
            rd_q    <= {LW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage, cleared on reset so o_data reads 0x00.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            mem_q[wr_q[AW-1:0]] <= byte_s;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign o_data     = mem_q[rd_q[AW-1:0]];
    assign o_valid    = valid_s;
    assign o_level    = level_s;
    assign o_overflow = ovf_q;
endmodule
